// File: rtl/pe_sequencer.sv
// pe_sequencer: control sequencer for one 1-D row convolution on a single PE.
// The load stream carries S filter words, then W ifmap words, into the PE
// scratchpads. The sequencer then issues E*S MAC cycles (E = W-S+1), drains
// the PE pipeline for PIPE_DEPTH cycles, and reads out E partial sums.
// Optional build macro: SEQ_CFG_CHECK_EN. When it is defined, an illegal start
// pulses err. When it is undefined, err is tied low and an illegal start is
// silently dropped.
module pe_sequencer #(
  parameter int PIPE_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] filt_len,
  input  logic [3:0] ifmap_len,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       pe_load_filter,
  output logic [5:0] pe_ld_addr_filter,
  output logic [7:0] pe_filter,
  output logic       pe_load_ifmap,
  output logic [3:0] pe_ld_addr_ifmap,
  output logic [7:0] pe_ifmap,
  output logic       pe_en,
  output logic [5:0] pe_sel_filter_addr,
  output logic [3:0] pe_sel_ifmap_addr,
  output logic [3:0] pe_psum_sel,
  output logic       pe_en_psum_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LD_FILT  = 3'd1;
  localparam logic [2:0] LD_IFMAP = 3'd2;
  localparam logic [2:0] COMPUTE  = 3'd3;
  localparam logic [2:0] DRAIN    = 3'd4;
  localparam logic [2:0] READOUT  = 3'd5;

  localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  logic [2:0]    state;
  logic [3:0]    s_len;
  logic [3:0]    w_len;
  logic [3:0]    e_len;
  logic [3:0]    k_cnt;
  logic [3:0]    e_cnt;
  logic [3:0]    s_cnt;
  logic [DW-1:0] d_cnt;
  logic          cfg_ok;
  logic          xfer;

  assign cfg_ok = (filt_len != 4'd0) && (ifmap_len >= filt_len);
  assign xfer   = in_valid && in_ready;

  // Main FSM. Each output register holds the value for the coming cycle, so
  // busy and in_ready track the state exactly. A scratchpad write appears
  // one cycle after its transfer. The MAC, drain and readout strobes appear
  // one cycle after the state cycle that issues them. This keeps the last
  // ifmap write and the first MAC in separate cycles. READOUT has one extra
  // state cycle, and that cycle issues done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      s_len              <= '0;
      w_len              <= '0;
      e_len              <= '0;
      k_cnt              <= '0;
      e_cnt              <= '0;
      s_cnt              <= '0;
      d_cnt              <= '0;
      in_ready           <= 1'b0;
      pe_load_filter     <= 1'b0;
      pe_ld_addr_filter  <= '0;
      pe_filter          <= '0;
      pe_load_ifmap      <= 1'b0;
      pe_ld_addr_ifmap   <= '0;
      pe_ifmap           <= '0;
      pe_en              <= 1'b0;
      pe_sel_filter_addr <= '0;
      pe_sel_ifmap_addr  <= '0;
      pe_psum_sel        <= '0;
      pe_en_psum_out     <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      pe_load_filter     <= 1'b0;
      pe_ld_addr_filter  <= '0;
      pe_filter          <= '0;
      pe_load_ifmap      <= 1'b0;
      pe_ld_addr_ifmap   <= '0;
      pe_ifmap           <= '0;
      pe_en              <= 1'b0;
      pe_sel_filter_addr <= '0;
      pe_sel_ifmap_addr  <= '0;
      pe_psum_sel        <= '0;
      pe_en_psum_out     <= 1'b0;
      done               <= 1'b0;
      case (state)
        IDLE: begin
          if (start && cfg_ok) begin
            s_len    <= filt_len;
            w_len    <= ifmap_len;
            e_len    <= ifmap_len - filt_len + 4'd1;
            k_cnt    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= LD_FILT;
          end
        end
        LD_FILT: begin
          if (xfer) begin
            pe_load_filter    <= 1'b1;
            pe_ld_addr_filter <= {2'b00, k_cnt};
            pe_filter         <= in_data;
            if (k_cnt == s_len - 4'd1) begin
              k_cnt <= '0;
              state <= LD_IFMAP;
            end else begin
              k_cnt <= k_cnt + 4'd1;
            end
          end
        end
        LD_IFMAP: begin
          if (xfer) begin
            pe_load_ifmap    <= 1'b1;
            pe_ld_addr_ifmap <= k_cnt;
            pe_ifmap         <= in_data;
            if (k_cnt == w_len - 4'd1) begin
              k_cnt    <= '0;
              e_cnt    <= '0;
              s_cnt    <= '0;
              in_ready <= 1'b0;
              state    <= COMPUTE;
            end else begin
              k_cnt <= k_cnt + 4'd1;
            end
          end
        end
        COMPUTE: begin
          pe_en              <= 1'b1;
          pe_sel_filter_addr <= {2'b00, s_cnt};
          pe_sel_ifmap_addr  <= e_cnt + s_cnt;
          pe_psum_sel        <= e_cnt;
          if (s_cnt == s_len - 4'd1) begin
            s_cnt <= '0;
            if (e_cnt == e_len - 4'd1) begin
              e_cnt <= '0;
              d_cnt <= '0;
              state <= (PIPE_DEPTH == 0) ? READOUT : DRAIN;
            end else begin
              e_cnt <= e_cnt + 4'd1;
            end
          end else begin
            s_cnt <= s_cnt + 4'd1;
          end
        end
        DRAIN: begin
          if (d_cnt == DW'(PIPE_DEPTH - 1)) begin
            state <= READOUT;
          end else begin
            d_cnt <= d_cnt + 1'b1;
          end
        end
        READOUT: begin
          if (e_cnt == e_len) begin
            e_cnt <= '0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            pe_en_psum_out <= 1'b1;
            pe_psum_sel    <= e_cnt;
            e_cnt          <= e_cnt + 4'd1;
          end
        end
        default: begin
          in_ready <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef SEQ_CFG_CHECK_EN
  logic err_q;

  // Flag a rejected configuration with a one-cycle pulse. The FSM stays in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && start && !cfg_ok;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/pe_sequencer.md
PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 Parameter: PIPE_DEPTH, 2, idle cycles inserted after the last MAC so the PE multiplier/adder pipeline drains.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  one-cycle request to run one 1-D row convolution.
REQ-005 filt_len  in  4  filter taps S, legal 1..15; sampled when start is accepted.
REQ-006 ifmap_len  in  4  ifmap words W, legal S..15; sampled when start is accepted.
REQ-007 in_valid / in_ready / in_data  in / out / in  1 / 1 / 8  load stream: S filter words, then W ifmap words.
REQ-008 pe_load_filter, pe_ld_addr_filter, pe_filter  out  1, 6, 8  filter scratchpad write port.
REQ-009 pe_load_ifmap, pe_ld_addr_ifmap, pe_ifmap  out  1, 4, 8  ifmap scratchpad write port.
REQ-010 pe_en, pe_sel_filter_addr, pe_sel_ifmap_addr, pe_psum_sel  out  1, 6, 4, 4  compute controls.
REQ-011 pe_en_psum_out  out  1  psum readout strobe.
REQ-012 busy, done, err  out  1 each  status; done and err are one-cycle pulses.

Function
REQ-013 States: IDLE, LD_FILT, LD_IFMAP, COMPUTE, DRAIN, READOUT; every output is registered.
REQ-014 IDLE: start=1 with legal config latches S and W, computes E=W-S+1, and moves to LD_FILT next cycle; start in any other state is ignored.
REQ-015 In LD_FILT and LD_IFMAP, in_ready=1 and words transfer on in_valid&in_ready; in_valid=0 stalls without loss.
REQ-016 The k-th filter transfer (k=0..S-1) drives, one cycle later, pe_load_filter=1, pe_ld_addr_filter=k, and pe_filter=word; after k=S-1, go to LD_IFMAP.
REQ-017 The k-th ifmap transfer (k=0..W-1) drives, one cycle later, pe_load_ifmap=1, pe_ld_addr_ifmap=k, and pe_ifmap=word; after k=W-1, go to COMPUTE.
REQ-018 pe_load_filter and pe_load_ifmap are never high together, and both are 0 whenever pe_en=1.
REQ-019 COMPUTE issues exactly E*S cycles with pe_en=1, in order e=0..E-1 (outer) and s=0..S-1 (inner), driving sel_filter=s, sel_ifmap=e+s, and psum_sel=e; no bubbles.
REQ-020 Each MAC cycle (e,s) also drives pe_en_psum_out=0; after the last MAC (e=E-1, s=S-1), go to DRAIN.
REQ-021 DRAIN holds pe_en=0 for exactly PIPE_DEPTH cycles, then goes to READOUT.
REQ-022 READOUT drives pe_en_psum_out=1 with psum_sel=e for e=0..E-1, one cycle each.
REQ-023 The cycle after READOUT ends, done=1 for one cycle and state returns to IDLE, and start is accepted in that same cycle.
REQ-024 busy=1 in every state except IDLE.
REQ-025 Counters use exact widths; sel_ifmap max is E-1+S-1=W-1≤14, and no wrap is permitted.
REQ-026 Boundary S=W: E=1, S MAC cycles.
REQ-027 Boundary S=1: E=W, W MAC cycles.

Reset
REQ-028 rst=1 forces IDLE immediately, at any time, including mid-load or mid-compute, and discards all counters.
REQ-029 While rst=1, all outputs are 0, including in_ready, busy, done, and err.
REQ-030 After rst falls, the first start is accepted normally.

Configuration
REQ-031 With SEQ_CFG_CHECK_EN defined, a start with S=0, W=0 or S>W pulses err=1 for one cycle and stays IDLE with no PE activity.
REQ-032 Without SEQ_CFG_CHECK_EN, err is tied 0 and an illegal start is silently dropped (stays IDLE, no done).

Verification
REQ-033 S=3, W=5, in_valid always 1, filter 1,2,3, ifmap 4..8 -> 3 filter writes to addr 0..2, then 5 ifmap writes to addr 0..4, then 9 MAC cycles with sel_ifmap sequence 0,1,2,1,2,3,2,3,4, then 2 drain cycles, 3 readout cycles with psum_sel 0,1,2, then done.
REQ-034 Same job with in_valid toggling 1,0 -> identical PE write contents, each write delayed only by stall cycles, and the MAC sequence unchanged.
REQ-035 S=W=15 -> 1 output, 15 MAC cycles with sel_filter=sel_ifmap=0..14, then 1 readout cycle.
REQ-036 rst asserted on the 4th MAC cycle -> all outputs 0 asynchronously; a new start after release completes with the correct full sequence.
REQ-037 start with S=4, W=2, checked against both macro settings -> err pulse and no load (macro defined), or no response at all (macro undefined); start asserted while busy -> ignored.
